if_pc_stage: RTL and testbench



---
 rtl/arm_pipe_pkg.sv | 15 +
 rtl/pc_next_sel.sv | 22 ++
 rtl/if_pc_stage.sv | 137 +++++++++++++
 tb/tb_if_pc_stage.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/arm_pipe_pkg.sv
// Shared types and constants for the ARMv8 pipeline fetch path.
// Pure declarations: no latency, no backpressure.
package arm_pipe_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_t;

    localparam int unsigned PC_INC    = 4;
    localparam logic [31:0] NOP_INSTR = 32'hD503201F;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC former: sequential PC+4 or word-aligned branch target.
// Purely combinational (zero latency), no backpressure.
module pc_next_sel
    import arm_pipe_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [ADDR_W-1:0] i_target,
    input  logic              i_sel,
    output logic [ADDR_W-1:0] o_next_pc
);

    logic [ADDR_W-1:0] w_seq_pc;
    logic [ADDR_W-1:0] w_target_aligned;

    // Addition wraps naturally at 2^ADDR_W.
    assign w_seq_pc         = i_pc + ADDR_W'(PC_INC);
    assign w_target_aligned = i_target & ~(ADDR_W'(PC_INC - 1));
    assign o_next_pc        = i_sel ? w_target_aligned : w_seq_pc;

endmodule

// File: rtl/if_pc_stage.sv
// Instruction-fetch stage: PC register, fetch FSM, IF/ID register; 2 cycles/instr at 1-cycle memory.
// stall holds PC and IF/ID (a response arriving during stall is parked in a hold buffer).
module if_pc_stage
    import arm_pipe_pkg::*;
#(
    parameter int              ADDR_W   = 64,
    parameter int              INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pc_src,
    input  logic [ADDR_W-1:0]  branch_target,
    input  logic               stall,
    input  logic               flush,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [ADDR_W-1:0]  ifid_pc,
    output logic [INSTR_W-1:0] ifid_instr,
    output logic               ifid_valid
);

    fetch_state_t        r_state;
    fetch_state_t        w_state_nxt;
    logic [ADDR_W-1:0]   r_pc;
    logic [INSTR_W-1:0]  r_hold;
    logic [ADDR_W-1:0]   r_ifid_pc;
    logic [INSTR_W-1:0]  r_ifid_instr;
    logic                r_ifid_valid;

    logic                w_load;
    logic                w_hold_cap;
    logic [INSTR_W-1:0]  w_load_instr;
    logic [ADDR_W-1:0]   w_next_pc;

    pc_next_sel #(.ADDR_W(ADDR_W)) u_pc_next_sel (
        .i_pc      (r_pc),
        .i_target  (branch_target),
        .i_sel     (pc_src),
        .o_next_pc (w_next_pc)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_hold_cap   = 1'b0;
        w_load_instr = imem_rdata;
        case (r_state)
            S_FETCH: w_state_nxt = pc_src ? S_DRAIN : S_WAIT;
            S_WAIT: begin
                if (imem_valid) begin
                    if (pc_src) begin
                        w_state_nxt = S_FETCH;
                    end else if (!stall) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_FETCH;
                    end else begin
                        w_hold_cap  = 1'b1;
                        w_state_nxt = S_HOLD;
                    end
                end else if (pc_src) begin
                    // Request still in flight: its response must be swallowed.
                    w_state_nxt = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (pc_src) begin
                    w_state_nxt = S_FETCH;
                end else if (!stall) begin
                    w_load       = 1'b1;
                    w_load_instr = r_hold;
                    w_state_nxt  = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (imem_valid) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A flushed load does not advance the PC, so the same address is refetched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc <= RESET_PC;
        end else if (pc_src || (w_load && !flush)) begin
            r_pc <= w_next_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
        end else if (pc_src) begin
            r_hold <= '0;
        end else if (w_hold_cap) begin
            r_hold <= imem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ifid_pc    <= '0;
            r_ifid_instr <= '0;
            r_ifid_valid <= 1'b0;
        end else if (pc_src || flush) begin
            r_ifid_instr <= INSTR_W'(NOP_INSTR);
            r_ifid_valid <= 1'b0;
        end else if (w_load) begin
            r_ifid_pc    <= r_pc;
            r_ifid_instr <= w_load_instr;
            r_ifid_valid <= 1'b1;
        end else if (!stall) begin
            r_ifid_valid <= 1'b0;
        end
    end

    // Gated by rst_n so no request escapes while reset is held.
    assign imem_req   = rst_n && (r_state == S_FETCH);
    assign imem_addr  = r_pc;
    assign ifid_pc    = r_ifid_pc;
    assign ifid_instr = r_ifid_instr;
    assign ifid_valid = r_ifid_valid;

endmodule

// File: tb/tb_if_pc_stage.sv
// Directed bench for if_pc_stage, with a second instance at a near-wrap reset PC.
// A simple responder answers one cycle after each request unless a test drives memory by hand.
module tb_if_pc_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_src = 1'b0;
    logic [63:0] branch_target = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = '0;

    logic        imem_req, w_imem_req;
    logic [63:0] imem_addr, w_imem_addr;
    logic [63:0] ifid_pc, w_ifid_pc;
    logic [31:0] ifid_instr, w_ifid_instr;
    logic        ifid_valid, w_ifid_valid;

    int          total = 0;
    int          bad = 0;
    logic        auto_mem = 1'b1;
    logic [31:0] mem_data = 32'h8B020020;
    logic        prev_req;

    always #5 clk = ~clk;

    if_pc_stage dut (
        .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .branch_target(branch_target),
        .stall(stall), .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata), .ifid_pc(ifid_pc),
        .ifid_instr(ifid_instr), .ifid_valid(ifid_valid)
    );

    if_pc_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_w (
        .clk(clk), .rst_n(rst_n), .pc_src(pc_src), .branch_target(branch_target),
        .stall(stall), .flush(flush), .imem_req(w_imem_req), .imem_addr(w_imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata), .ifid_pc(w_ifid_pc),
        .ifid_instr(w_ifid_instr), .ifid_valid(w_ifid_valid)
    );

    task automatic tick();
        #1;
        prev_req = imem_req;
        @(posedge clk);
        #1;
        if (auto_mem) begin
            imem_valid = prev_req;
            imem_rdata = mem_data;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; pc_src = 1'b0; stall = 1'b0; flush = 1'b0;
        imem_valid = 1'b0; auto_mem = 1'b1; mem_data = 32'h8B020020;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
        total++; if (w_imem_req !== 1'b0) begin bad++; $display("FAIL rst_req_w: got %b want 0", w_imem_req); end
        total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", ifid_valid); end
        total++; if (ifid_pc !== 64'h0) begin bad++; $display("FAIL rst_ifid_pc: got %h want 0", ifid_pc); end
        total++; if (ifid_instr !== 32'h0) begin bad++; $display("FAIL rst_ifid_instr: got %h want 0", ifid_instr); end
        total++; if (imem_addr !== 64'h0) begin bad++; $display("FAIL rst_pc: got %h want 0", imem_addr); end
    endtask

    task automatic test_basic_fetch();
        do_reset();
        total++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin bad++; $display("FAIL basic_req0: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
        total++; if (w_imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL wrap_addr0: got %h want fffffffffffffffc", w_imem_addr); end
        tick();
        total++; if (imem_req !== 1'b0 || ifid_valid !== 1'b0) begin bad++; $display("FAIL basic_wait: got req=%b valid=%b want 0/0", imem_req, ifid_valid); end
        tick();
        total++; if (ifid_valid !== 1'b1 || ifid_pc !== 64'h0 || ifid_instr !== 32'h8B020020) begin bad++; $display("FAIL basic_ifid0: got v=%b pc=%h i=%h want 1/0/8b020020", ifid_valid, ifid_pc, ifid_instr); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 64'h4) begin bad++; $display("FAIL basic_req4: got req=%b addr=%h want 1/4", imem_req, imem_addr); end
        total++; if (w_imem_req !== 1'b1 || w_imem_addr !== 64'h0) begin bad++; $display("FAIL wrap_addr1: got req=%b addr=%h want 1/0", w_imem_req, w_imem_addr); end
        total++; if (w_ifid_pc !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL wrap_ifid_pc: got %h want fffffffffffffffc", w_ifid_pc); end
        tick();
        total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL basic_bubble: got %b want 0", ifid_valid); end
        tick();
        total++; if (ifid_valid !== 1'b1 || ifid_pc !== 64'h4) begin bad++; $display("FAIL basic_ifid4: got v=%b pc=%h want 1/4", ifid_valid, ifid_pc); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 64'h8) begin bad++; $display("FAIL basic_req8: got req=%b addr=%h want 1/8", imem_req, imem_addr); end
    endtask

    task automatic test_stall();
        do_reset();
        tick();
        tick();
        stall = 1'b1;
        mem_data = 32'hAAAA0004;
        tick();
        total++; if (ifid_valid !== 1'b1 || ifid_pc !== 64'h0 || ifid_instr !== 32'h8B020020) begin bad++; $display("FAIL stall_hold1: got v=%b pc=%h i=%h want 1/0/8b020020", ifid_valid, ifid_pc, ifid_instr); end
        tick();
        total++; if (ifid_valid !== 1'b1 || ifid_pc !== 64'h0) begin bad++; $display("FAIL stall_hold2: got v=%b pc=%h want 1/0", ifid_valid, ifid_pc); end
        total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_nodup1: got %b want 0", imem_req); end
        tick();
        total++; if (imem_req !== 1'b0 || ifid_pc !== 64'h0) begin bad++; $display("FAIL stall_nodup2: got req=%b pc=%h want 0/0", imem_req, ifid_pc); end
        stall = 1'b0;
        tick();
        total++; if (ifid_valid !== 1'b1 || ifid_pc !== 64'h4 || ifid_instr !== 32'hAAAA0004) begin bad++; $display("FAIL stall_release: got v=%b pc=%h i=%h want 1/4/aaaa0004", ifid_valid, ifid_pc, ifid_instr); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 64'h8) begin bad++; $display("FAIL stall_next_req: got req=%b addr=%h want 1/8", imem_req, imem_addr); end
    endtask

    task automatic test_redirect();
        do_reset();
        auto_mem = 1'b0;
        tick();
        pc_src = 1'b1;
        branch_target = 64'h1003;
        tick();
        pc_src = 1'b0;
        total++; if (imem_req !== 1'b0 || ifid_valid !== 1'b0) begin bad++; $display("FAIL redir_drain: got req=%b v=%b want 0/0", imem_req, ifid_valid); end
        imem_valid = 1'b1;
        imem_rdata = 32'hDEADBEEF;
        tick();
        imem_valid = 1'b0;
        total++; if (imem_req !== 1'b1 || imem_addr !== 64'h1000) begin bad++; $display("FAIL redir_addr: got req=%b addr=%h want 1/1000", imem_req, imem_addr); end
        total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL redir_stale: got %b want 0", ifid_valid); end
        tick();
        imem_valid = 1'b1;
        imem_rdata = 32'h11111111;
        tick();
        imem_valid = 1'b0;
        total++; if (ifid_valid !== 1'b1 || ifid_pc !== 64'h1000 || ifid_instr !== 32'h11111111) begin bad++; $display("FAIL redir_load: got v=%b pc=%h i=%h want 1/1000/11111111", ifid_valid, ifid_pc, ifid_instr); end
    endtask

    task automatic test_flush();
        do_reset();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", ifid_valid); end
        total++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin bad++; $display("FAIL flush_pc: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
        tick();
        tick();
        total++; if (ifid_valid !== 1'b1 || ifid_pc !== 64'h0 || imem_addr !== 64'h4) begin bad++; $display("FAIL flush_refetch: got v=%b pc=%h addr=%h want 1/0/4", ifid_valid, ifid_pc, imem_addr); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        auto_mem = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        total++; if (imem_req !== 1'b0 || ifid_valid !== 1'b0) begin bad++; $display("FAIL midrst_async: got req=%b v=%b want 0/0", imem_req, ifid_valid); end
        tick();
        rst_n = 1'b1;
        imem_valid = 1'b1;
        imem_rdata = 32'hCAFE0000;
        #1;
        total++; if (imem_req !== 1'b1 || imem_addr !== 64'h0) begin bad++; $display("FAIL midrst_first: got req=%b addr=%h want 1/0", imem_req, imem_addr); end
        total++; if (w_imem_addr !== 64'hFFFF_FFFF_FFFF_FFFC) begin bad++; $display("FAIL midrst_first_w: got %h want fffffffffffffffc", w_imem_addr); end
        tick();
        imem_valid = 1'b0;
        total++; if (ifid_valid !== 1'b0 || imem_req !== 1'b0) begin bad++; $display("FAIL midrst_ignored: got v=%b req=%b want 0/0", ifid_valid, imem_req); end
        tick();
        total++; if (ifid_valid !== 1'b0) begin bad++; $display("FAIL midrst_still_empty: got %b want 0", ifid_valid); end
    endtask

    initial begin
        test_reset();
        test_basic_fetch();
        test_stall();
        test_redirect();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
